// File: rtl/cpuclk_switch_m.sv
// Glitch-free CPU clock switch between a synchronised low-speed clock (BBC phi0)
// and an hsclk-derived divider, with every flop on hsclk.
module cpuclk_switch_m #(
  parameter int DIV_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             hsclk,
  input  logic             resetb,
  input  logic             lsclk_in,
  input  logic             hsclk_sel,
  input  logic [DIV_W-1:0] hsclk_div_sel,
  output logic             cpuclk,
  output logic             hs_active,
  output logic             switch_busy
);

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    LS2HS  = 2'd1,
    HS_RUN = 2'd2,
    HS2LS  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_lsclk_d;
  logic                   r_cpuclk;
  logic                   w_cpuclk_nxt;
  logic [DIV_W-1:0]       r_cnt;
  logic [DIV_W-1:0]       w_cnt_nxt;
  logic [DIV_W-1:0]       r_div_q;
  logic [DIV_W-1:0]       w_div_q_nxt;
  logic                   w_lsclk_s;
  logic                   w_ls_fall;
  logic                   w_div_run;

  // lsclk_in is asynchronous and treated purely as data from here on.
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      r_sync    <= '0;
      r_lsclk_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], lsclk_in};
      r_lsclk_d <= w_lsclk_s;
    end
  end

  assign w_lsclk_s = r_sync[SYNC_STAGES-1];
  assign w_ls_fall = r_lsclk_d & ~w_lsclk_s;

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      r_state  <= LS_RUN;
      r_cpuclk <= 1'b0;
      r_cnt    <= '0;
      r_div_q  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cpuclk <= w_cpuclk_nxt;
      r_cnt    <= w_cnt_nxt;
      r_div_q  <= w_div_q_nxt;
    end
  end

  // Hand-overs only happen while cpuclk is low, so neither clock source can cut a phase short.
  always_comb begin
    w_state_nxt  = r_state;
    w_cpuclk_nxt = r_cpuclk;
    w_cnt_nxt    = r_cnt;
    w_div_q_nxt  = r_div_q;
    w_div_run    = 1'b0;

    case (r_state)
      LS_RUN: begin
        w_cpuclk_nxt = w_lsclk_s;
        if (hsclk_sel) begin
          w_state_nxt = LS2HS;
        end
      end
      LS2HS: begin
        if (!hsclk_sel) begin
          w_state_nxt  = LS_RUN;
          w_cpuclk_nxt = w_lsclk_s;
        end else if (w_ls_fall) begin
          w_state_nxt  = HS_RUN;
          w_cpuclk_nxt = 1'b0;
          w_cnt_nxt    = '0;
          w_div_q_nxt  = hsclk_div_sel;
        end else begin
          w_cpuclk_nxt = w_lsclk_s;
        end
      end
      HS_RUN: begin
        w_div_run = 1'b1;
        if (!hsclk_sel) begin
          w_state_nxt = HS2LS;
        end
      end
      HS2LS: begin
        if (hsclk_sel) begin
          w_state_nxt = HS_RUN;
          w_div_run   = 1'b1;
        end else if (r_cpuclk) begin
          w_div_run = 1'b1;
        end else if (w_ls_fall) begin
          w_state_nxt = LS_RUN;
        end
      end
      default: begin
        w_state_nxt  = LS_RUN;
        w_cpuclk_nxt = 1'b0;
      end
    endcase

    // The divide ratio is only sampled at a phase boundary, so a running phase keeps its length.
    if (w_div_run) begin
      if (r_cnt == r_div_q) begin
        w_cpuclk_nxt = ~r_cpuclk;
        w_cnt_nxt    = '0;
        w_div_q_nxt  = hsclk_div_sel;
      end else begin
        w_cnt_nxt = r_cnt + DIV_W'(1);
      end
    end
  end

  assign cpuclk      = r_cpuclk;
  assign hs_active   = (r_state == HS_RUN);
  assign switch_busy = (r_state == LS2HS) || (r_state == HS2LS);

endmodule

// File: tb/tb_cpuclk_switch_m.sv
// Bench for cpuclk_switch_m: directed vector table, hand-built switch corner cases,
// then random traffic checked against a cycle-level reference model.
module tb_cpuclk_switch_m;

  localparam int DIV_W = 3;
  localparam int SYNC  = 2;

  localparam int M_LS   = 0;
  localparam int M_GOHS = 1;
  localparam int M_HS   = 2;
  localparam int M_GOLS = 3;

  logic             hsclk     = 1'b0;
  logic             resetb    = 1'b0;
  logic             lsclk_in  = 1'b0;
  logic             hsclk_sel = 1'b0;
  logic [DIV_W-1:0] divSel    = '0;
  logic             cpuclk;
  logic             hsActive;
  logic             switchBusy;

  int errors = 0;
  int checks = 0;

  int lsHalf = 8;
  int lsCnt  = 0;
  bit lsRand = 1'b0;

  cpuclk_switch_m #(.DIV_W(DIV_W), .SYNC_STAGES(SYNC)) dut (
    .hsclk        (hsclk),
    .resetb       (resetb),
    .lsclk_in     (lsclk_in),
    .hsclk_sel    (hsclk_sel),
    .hsclk_div_sel(divSel),
    .cpuclk       (cpuclk),
    .hs_active    (hsActive),
    .switch_busy  (switchBusy)
  );

  always #5 hsclk = ~hsclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode plus a countdown of cycles left in the current clock phase.
  int mMode = M_LS;
  bit mClk  = 1'b0;
  int mLeft = 1;
  bit mHist [SYNC];
  bit mDly  = 1'b0;

  always @(posedge hsclk or negedge resetb) begin : refModel
    bit s;
    bit fall;
    bit run;
    if (!resetb) begin
      mMode = M_LS;
      mClk  = 1'b0;
      mLeft = 1;
      mDly  = 1'b0;
      for (int i = 0; i < SYNC; i++) mHist[i] = 1'b0;
    end else begin
      s    = mHist[SYNC-1];
      fall = mDly && !s;
      run  = 1'b0;
      case (mMode)
        M_LS: begin
          mClk = s;
          if (hsclk_sel) mMode = M_GOHS;
        end
        M_GOHS: begin
          if (!hsclk_sel) begin
            mMode = M_LS;
            mClk  = s;
          end else if (fall) begin
            mMode = M_HS;
            mClk  = 1'b0;
            mLeft = int'(divSel) + 1;
          end else begin
            mClk = s;
          end
        end
        M_HS: begin
          run = 1'b1;
          if (!hsclk_sel) mMode = M_GOLS;
        end
        default: begin
          if (hsclk_sel) begin
            mMode = M_HS;
            run   = 1'b1;
          end else if (mClk) begin
            run = 1'b1;
          end else if (fall) begin
            mMode = M_LS;
          end
        end
      endcase
      if (run) begin
        if (mLeft == 1) begin
          mClk  = !mClk;
          mLeft = int'(divSel) + 1;
        end else begin
          mLeft--;
        end
      end
      mDly = s;
      for (int i = SYNC - 1; i > 0; i--) mHist[i] = mHist[i-1];
      mHist[0] = lsclk_in;
    end
  end

  // Every cycle the DUT is compared with the model, well away from the clock edge.
  always @(posedge hsclk) begin
    #3;
    checkOutput("model_cpuclk", cpuclk, mClk);
    checkOutput("model_hs_active", hsActive, mMode == M_HS);
    checkOutput("model_switch_busy", switchBusy, (mMode == M_GOHS) || (mMode == M_GOLS));
  end

  // Advance n cycles from a falling edge, generating lsclk_in as a square wave.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge hsclk);
      #5;
      lsCnt++;
      if (lsCnt >= lsHalf) begin
        lsCnt    = 0;
        lsclk_in = !lsclk_in;
        if (lsRand) lsHalf = $urandom_range(5, 12);
      end
    end
  endtask

  typedef struct {
    bit               rb;
    bit               ls;
    bit               sel;
    logic [DIV_W-1:0] div;
    bit               expClk;
    bit               expHs;
    bit               expBusy;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input bit rb, input bit ls, input bit sel, input int div,
                        input bit c, input bit h, input bit b);
    vec_t v;
    v.rb      = rb;
    v.ls      = ls;
    v.sel     = sel;
    v.div     = div[DIV_W-1:0];
    v.expClk  = c;
    v.expHs   = h;
    v.expBusy = b;
    vecs.push_back(v);
  endtask

  initial begin
    int  runLen;
    bit  prev;
    bit  first;
    bit  found;

    // reset, then lsclk tracking with three-cycle latency
    addVec(0, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 0, 0, 0);
    addVec(1, 1, 0, 0, 1, 0, 0);
    // request HS: busy until the synchronised lsclk falls
    addVec(1, 0, 1, 0, 1, 0, 1);
    addVec(1, 0, 1, 0, 1, 0, 1);
    addVec(1, 0, 1, 3, 0, 1, 0);
    addVec(1, 0, 1, 3, 0, 1, 0);
    addVec(1, 0, 1, 3, 0, 1, 0);
    addVec(1, 0, 1, 3, 0, 1, 0);
    addVec(1, 0, 1, 3, 1, 1, 0);
    // ratio 3 -> 0 mid high phase: phase still lasts four cycles
    addVec(1, 0, 1, 0, 1, 1, 0);
    addVec(1, 0, 1, 0, 1, 1, 0);
    addVec(1, 0, 1, 0, 1, 1, 0);
    addVec(1, 0, 1, 0, 0, 1, 0);
    addVec(1, 0, 1, 0, 1, 1, 0);
    addVec(1, 0, 1, 3, 0, 1, 0);
    addVec(1, 0, 1, 3, 0, 1, 0);
    addVec(1, 0, 1, 3, 0, 1, 0);
    addVec(1, 0, 1, 3, 0, 1, 0);
    addVec(1, 0, 1, 3, 1, 1, 0);
    // drop HS while high: high phase completes, then held low
    addVec(1, 0, 0, 3, 1, 0, 1);
    addVec(1, 0, 0, 3, 1, 0, 1);
    addVec(1, 0, 0, 3, 1, 0, 1);
    addVec(1, 0, 0, 3, 0, 0, 1);
    addVec(1, 1, 0, 3, 0, 0, 1);
    addVec(1, 1, 0, 3, 0, 0, 1);
    addVec(1, 1, 0, 3, 0, 0, 1);
    addVec(1, 0, 0, 3, 0, 0, 1);
    addVec(1, 0, 0, 3, 0, 0, 1);
    addVec(1, 0, 0, 3, 0, 0, 0);
    addVec(1, 1, 0, 3, 0, 0, 0);
    addVec(1, 1, 0, 3, 0, 0, 0);
    addVec(1, 1, 0, 3, 1, 0, 0);

    foreach (vecs[i]) begin
      resetb    = vecs[i].rb;
      lsclk_in  = vecs[i].ls;
      hsclk_sel = vecs[i].sel;
      divSel    = vecs[i].div;
      @(posedge hsclk);
      #2;
      checkOutput($sformatf("vec%0d_cpuclk", i), cpuclk, vecs[i].expClk);
      checkOutput($sformatf("vec%0d_hs_active", i), hsActive, vecs[i].expHs);
      checkOutput($sformatf("vec%0d_switch_busy", i), switchBusy, vecs[i].expBusy);
      #3;
    end

    // abort a pending LS->HS switch well before any lsclk fall
    lsCnt     = 0;
    hsclk_sel = 1'b0;
    applyStimulus(20);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (lsclk_in && lsCnt == 0) found = 1'b1;
      else applyStimulus(1);
    end
    checkOutput("abort_wait_ls_rise", found, 1'b1);
    hsclk_sel = 1'b1;
    applyStimulus(2);
    checkOutput("ls2hs_busy", switchBusy, 1'b1);
    hsclk_sel = 1'b0;
    applyStimulus(1);
    checkOutput("abort_busy", switchBusy, 1'b0);
    checkOutput("abort_hs_active", hsActive, 1'b0);

    // abort arriving on the very cycle the lsclk fall is seen
    applyStimulus(3);
    hsclk_sel = 1'b1;
    found     = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      applyStimulus(1);
      if (mMode == M_GOHS && mDly && !mHist[SYNC-1]) found = 1'b1;
    end
    checkOutput("coincide_wait_fall", found, 1'b1);
    hsclk_sel = 1'b0;
    applyStimulus(1);
    checkOutput("coincide_hs_active", hsActive, 1'b0);
    checkOutput("coincide_busy", switchBusy, 1'b0);

    // enter HS at ratio 3, briefly drop the request, re-request, phases stay 4 cycles
    divSel    = 3'd3;
    hsclk_sel = 1'b1;
    found     = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      applyStimulus(1);
      if (mMode == M_HS) found = 1'b1;
    end
    checkOutput("hs_entry_wait", found, 1'b1);
    applyStimulus(6);
    hsclk_sel = 1'b0;
    applyStimulus(2);
    checkOutput("rereq_busy", switchBusy, 1'b1);
    hsclk_sel = 1'b1;
    prev   = cpuclk;
    first  = 1'b1;
    runLen = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1);
      if (cpuclk == prev) begin
        runLen++;
      end else begin
        if (!first) checkOutput("rereq_phase_len", runLen, 4);
        first  = 1'b0;
        runLen = 1;
        prev   = cpuclk;
      end
    end
    checkOutput("rereq_hs_active", hsActive, 1'b1);

    // reset in the middle of HS->LS
    hsclk_sel = 1'b0;
    applyStimulus(1);
    checkOutput("hs2ls_busy", switchBusy, 1'b1);
    resetb = 1'b0;
    #1;
    checkOutput("rst_cpuclk", cpuclk, 1'b0);
    checkOutput("rst_hs_active", hsActive, 1'b0);
    checkOutput("rst_busy", switchBusy, 1'b0);
    applyStimulus(2);
    resetb = 1'b1;
    applyStimulus(40);
    checkOutput("post_rst_hs_active", hsActive, 1'b0);

    // random traffic
    lsRand = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) hsclk_sel = !hsclk_sel;
      if ($urandom_range(0, 29) == 0) divSel = DIV_W'($urandom_range(0, (1 << DIV_W) - 1));
      if ($urandom_range(0, 599) == 0) begin
        resetb = 1'b0;
        applyStimulus($urandom_range(1, 3));
        resetb = 1'b1;
      end
      applyStimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
